quadrature_decoder: RTL and testbench
=====================================

QUADRATURE_DECODER -- requirements
Module: quadrature_decoder

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of input synchronizer flops (minimum 2).
REQ-002 Parameter FILT_W, default 8, width of the glitch-filter length register.
REQ-003 csi_MCLK_clk  in  1  system clock; all logic runs in this single domain.
REQ-004 rsi_MRST_reset  in  1  reset, asynchronous, active-high.
REQ-005 avs_ctrl_address  in  3  register word address.
REQ-006 avs_ctrl_write / avs_ctrl_read  in  1 each  Avalon-MM strobes.
REQ-007 avs_ctrl_writedata  in  32, avs_ctrl_byteenable  in  4  write data and byte lanes.
REQ-008 avs_ctrl_readdata  out  32  registered read data; avs_ctrl_waitrequest  out  1  tied 0.
REQ-009 enc_a, enc_b  in  1 each  asynchronous encoder quadrature channels.
REQ-010 enc_z  in  1  asynchronous encoder index pulse (present only with QDEC_INDEX_EN).
REQ-011 dir  out  1  last counted direction (1 = forward); irq  out  1  index event pending.

Function
REQ-012 Register map: 0 POSITION (RW, signed 32b); 1 FILTER (RW, FILT_W LSBs); 2 CONTROL (RW: bit0 enable, bit1 reverse); 3 STATUS (R: [31:16] error count, bit1 dir, bit0 index_seen; W1C bit0, W1 bit8 clears error count); 4 INDEX_POS (R).
REQ-013 Writes honour byteenable per byte; writes to read-only bits and to unmapped addresses are ignored.
REQ-014 Reads return data on avs_ctrl_readdata one clock after the read strobe; unmapped addresses read 0.
REQ-015 Each input passes SYNC_STAGES flops, then a filter: filtered value changes only after the synced input differs from it for FILTER+1 consecutive clocks; FILTER=0 gives one clock of filter latency.
REQ-016 Decoder holds previous filtered {A,B}; forward sequence 00->01->11->10->00 gives +1, reverse sequence gives -1 (x4 decode), applied the clock after the filtered change.
REQ-017 CONTROL.reverse = 1 swaps the sign of every count and of dir.
REQ-018 Both filtered bits changing in the same clock: no count, error count +1, saturating at 0xFFFF.
REQ-019 POSITION wraps modulo 2^32 (0x7FFFFFFF +1 -> 0x80000000, 0 -1 -> 0xFFFFFFFF).
REQ-020 CONTROL.enable = 0: the filter and previous-state register keep tracking, no counts or errors are applied.
REQ-021 Bus write to POSITION in the same clock as a count event: the written value wins and the count is dropped.
REQ-022 dir updates only on a counted step; errors leave dir unchanged.

Reset
REQ-023 Reset clears POSITION, INDEX_POS, error count, index_seen, dir, irq, readdata and CONTROL to 0, and sets FILTER to 3.
REQ-024 Synchronizer and filter flops reset to 0; previous state is loaded from the first filtered sample after reset, so no count occurs on that sample.
REQ-025 Reset asserted mid-count aborts any pending update; the first count after release starts from 0.

Configuration
REQ-026 Macro QDEC_INDEX_EN defined: enc_z port exists with the same sync/filter path as A/B.
REQ-027 With QDEC_INDEX_EN, a filtered enc_z rising edge while enabled copies POSITION (the value before that clock's count) to INDEX_POS and sets index_seen; irq = index_seen.
REQ-028 Without QDEC_INDEX_EN: no enc_z port; INDEX_POS and index_seen read 0; irq is tied 0.

Structure
REQ-029 Shared package qdec_pkg holds register address constants, CONTROL/STATUS bit positions, and the FILTER reset value.
REQ-030 Sub-module qdec_filter (sync chain plus stability counter, one instance per input) is instantiated 2 or 3 times.

Verification
REQ-031 FILTER=0, enable=1: drive 8 forward quadrature steps, 20 clocks apart -> POSITION reads 8 and dir=1.
REQ-032 Preload POSITION=0, drive 1 reverse step -> POSITION reads 0xFFFFFFFF and dir=0; set reverse=1 and repeat the same step -> POSITION reads 0.
REQ-033 FILTER=3: a 3-clock glitch on enc_a -> no count and no error; a 5-clock-stable edge -> one count.
REQ-034 Toggle A and B in the same clock from 00 to 11 -> STATUS[31:16]=1 and POSITION unchanged; write bit8 -> error count reads 0.
REQ-035 (QDEC_INDEX_EN) POSITION=100, then a Z rising edge -> INDEX_POS=100 and irq=1; W1C STATUS bit0 -> irq=0.
REQ-036 Write POSITION=0x55 in the same clock as a count event, and assert reset mid-stream -> reads 0x55 after the write, and all registers match REQ-023 after the reset.

Source files
------------

// File: rtl/qdec_pkg.sv
// -----------------------------------------------------------------------------
// qdec_pkg
// Shared definitions for the quadrature decoder:
//   - register word addresses of the Avalon-MM control slave
//   - CONTROL / STATUS bit positions
//   - reset value of the glitch-filter length register
//   - quadrature transition classification (step_e, qdec_decode)
//   - byte-lane merge helper for byteenable-qualified writes
// -----------------------------------------------------------------------------
package qdec_pkg;

    localparam logic [2:0] ADDR_POSITION  = 3'd0;
    localparam logic [2:0] ADDR_FILTER    = 3'd1;
    localparam logic [2:0] ADDR_CONTROL   = 3'd2;
    localparam logic [2:0] ADDR_STATUS    = 3'd3;
    localparam logic [2:0] ADDR_INDEX_POS = 3'd4;

    localparam int unsigned CTRL_EN_BIT     = 32'd0;
    localparam int unsigned CTRL_REV_BIT    = 32'd1;
    localparam int unsigned STAT_INDEX_BIT  = 32'd0;
    localparam int unsigned STAT_DIR_BIT    = 32'd1;
    localparam int unsigned STAT_ERRCLR_BIT = 32'd8;

    localparam int unsigned FILTER_RESET = 32'd3;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_FWD  = 2'd1,
        STEP_REV  = 2'd2,
        STEP_ERR  = 2'd3
    } step_e;

    // Classify a transition of the filtered {A,B} pair (x4 decode).
    // Forward order is 00 -> 01 -> 11 -> 10 -> 00.
    function automatic step_e qdec_decode(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
        step_e s;
        case ({prev_ab, cur_ab})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: s = STEP_FWD;
            4'b0010, 4'b1011, 4'b1101, 4'b0100: s = STEP_REV;
            4'b0011, 4'b1100, 4'b0110, 4'b1001: s = STEP_ERR;
            default:                            s = STEP_NONE;
        endcase
        return s;
    endfunction

    // Replace the byte lanes of old_v selected by be with the lanes of new_v.
    function automatic logic [31:0] be_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] be);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                r[8*i +: 8] = new_v[8*i +: 8];
            end else begin
                r[8*i +: 8] = old_v[8*i +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/quadrature_decoder_filter.sv
// -----------------------------------------------------------------------------
// qdec_filter
// One asynchronous encoder channel: SYNC_STAGES-deep synchronizer followed by a
// stability filter. The output follows the synchronized input only after the
// two have differed for filt_len+1 consecutive clocks (filt_len = 0 still
// costs one clock).
// Ports:
//   csi_MCLK_clk    system clock
//   rsi_MRST_reset  asynchronous active-high reset (all flops to 0)
//   din             asynchronous input
//   filt_len        filter length (FILT_W bits)
//   dout            filtered, registered output
// -----------------------------------------------------------------------------
module qdec_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 8
) (
    input  logic              csi_MCLK_clk,
    input  logic              rsi_MRST_reset,
    input  logic              din,
    input  logic [FILT_W-1:0] filt_len,
    output logic              dout
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic [FILT_W-1:0]      cnt_r;
    logic                   dout_r;
    logic                   synced_s;

    assign synced_s = sync_r[SYNC_STAGES-1];
    assign dout     = dout_r;

    // Synchronizer chain for the asynchronous input.
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], din};
        end
    end

    // Stability counter: counts clocks of disagreement, restarts on agreement.
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            cnt_r  <= '0;
            dout_r <= 1'b0;
        end else if (synced_s == dout_r) begin
            cnt_r <= '0;
        end else if (cnt_r >= filt_len) begin
            dout_r <= synced_s;
            cnt_r  <= '0;
        end else begin
            cnt_r <= cnt_r + {{(FILT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/quadrature_decoder.sv
// -----------------------------------------------------------------------------
// quadrature_decoder
// x4 quadrature decoder with an Avalon-MM control slave.
// Optional feature macro: QDEC_INDEX_EN (adds enc_z index input, INDEX_POS
// capture, index_seen flag and irq). Without it, enc_z is absent, INDEX_POS and
// index_seen read 0 and irq is 0.
// Register map (word addresses):
//   0 POSITION  RW signed 32b, wraps modulo 2^32
//   1 FILTER    RW, FILT_W LSBs, resets to 3
//   2 CONTROL   RW bit0 enable, bit1 reverse
//   3 STATUS    R [31:16] error count, bit1 dir, bit0 index_seen;
//               W1C bit0 (index_seen), W1 bit8 clears error count
//   4 INDEX_POS R
// Ports:
//   csi_MCLK_clk, rsi_MRST_reset (async, active-high)
//   avs_ctrl_* : Avalon-MM slave, read data one clock after read, no wait states
//   enc_a, enc_b (, enc_z) : asynchronous encoder inputs
//   dir : last counted direction (1 = forward), irq : index event pending
// -----------------------------------------------------------------------------
module quadrature_decoder
    import qdec_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 8
) (
    input  logic        csi_MCLK_clk,
    input  logic        rsi_MRST_reset,
    input  logic [2:0]  avs_ctrl_address,
    input  logic        avs_ctrl_write,
    input  logic        avs_ctrl_read,
    input  logic [31:0] avs_ctrl_writedata,
    input  logic [3:0]  avs_ctrl_byteenable,
    output logic [31:0] avs_ctrl_readdata,
    output logic        avs_ctrl_waitrequest,
    input  logic        enc_a,
    input  logic        enc_b,
`ifdef QDEC_INDEX_EN
    input  logic        enc_z,
`endif
    output logic        dir,
    output logic        irq
);

    logic [31:0]       position_r;
    logic [FILT_W-1:0] filt_len_r;
    logic [1:0]        ctrl_r;
    logic [15:0]       err_cnt_r;
    logic              dir_r;
    logic [1:0]        prev_r;
    logic              prev_valid_r;
    logic [31:0]       readdata_r;

    logic              fa_s;
    logic              fb_s;
    logic [1:0]        ab_s;
    step_e             step_s;
    logic              cnt_evt_s;
    logic              cnt_up_s;
    logic              err_evt_s;
    logic              wr_pos_s;
    logic              wr_filt_s;
    logic              wr_ctrl_s;
    logic              err_clr_s;
    logic [FILT_W-1:0] filt_nxt_s;
    logic [31:0]       rd_mux_s;
    logic              index_seen_s;
    logic [31:0]       index_pos_s;

    assign avs_ctrl_waitrequest = 1'b0;
    assign avs_ctrl_readdata    = readdata_r;
    assign dir                  = dir_r;

    qdec_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_W(FILT_W)) u_filt_a (
        .csi_MCLK_clk   (csi_MCLK_clk),
        .rsi_MRST_reset (rsi_MRST_reset),
        .din            (enc_a),
        .filt_len       (filt_len_r),
        .dout           (fa_s)
    );

    qdec_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_W(FILT_W)) u_filt_b (
        .csi_MCLK_clk   (csi_MCLK_clk),
        .rsi_MRST_reset (rsi_MRST_reset),
        .din            (enc_b),
        .filt_len       (filt_len_r),
        .dout           (fb_s)
    );

    assign ab_s = {fa_s, fb_s};

    // Bus write decode.
    always_comb begin
        wr_pos_s  = avs_ctrl_write && (avs_ctrl_address == ADDR_POSITION);
        wr_filt_s = avs_ctrl_write && (avs_ctrl_address == ADDR_FILTER);
        wr_ctrl_s = avs_ctrl_write && (avs_ctrl_address == ADDR_CONTROL);
        err_clr_s = avs_ctrl_write && (avs_ctrl_address == ADDR_STATUS) &&
                    avs_ctrl_byteenable[1] && avs_ctrl_writedata[STAT_ERRCLR_BIT];
    end

    // FILTER next value: each bit takes write data only where its byte lane is enabled.
    always_comb begin
        filt_nxt_s = filt_len_r;
        for (int i = 0; i < FILT_W; i++) begin
            if (avs_ctrl_byteenable[i/8]) begin
                filt_nxt_s[i] = avs_ctrl_writedata[i];
            end else begin
                filt_nxt_s[i] = filt_len_r[i];
            end
        end
    end

    // Step classification; nothing counts until the previous state holds a real sample.
    always_comb begin
        step_s    = qdec_decode(prev_r, ab_s);
        cnt_evt_s = 1'b0;
        cnt_up_s  = 1'b0;
        err_evt_s = 1'b0;
        if (ctrl_r[CTRL_EN_BIT] && prev_valid_r) begin
            case (step_s)
                STEP_FWD: begin
                    cnt_evt_s = 1'b1;
                    cnt_up_s  = ~ctrl_r[CTRL_REV_BIT];
                end
                STEP_REV: begin
                    cnt_evt_s = 1'b1;
                    cnt_up_s  = ctrl_r[CTRL_REV_BIT];
                end
                STEP_ERR: begin
                    err_evt_s = 1'b1;
                end
                default: begin
                    cnt_evt_s = 1'b0;
                end
            endcase
        end else begin
            cnt_evt_s = 1'b0;
        end
    end

    // Previous-state tracking; runs regardless of enable.
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            prev_r       <= 2'b00;
            prev_valid_r <= 1'b0;
        end else begin
            prev_r       <= ab_s;
            prev_valid_r <= 1'b1;
        end
    end

    // Position counter and direction; a bus write overrides a same-clock count.
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            position_r <= 32'd0;
            dir_r      <= 1'b0;
        end else if (wr_pos_s) begin
            position_r <= be_merge(position_r, avs_ctrl_writedata, avs_ctrl_byteenable);
        end else if (cnt_evt_s) begin
            position_r <= cnt_up_s ? (position_r + 32'd1) : (position_r - 32'd1);
            dir_r      <= cnt_up_s;
        end
    end

    // Saturating error counter for illegal double transitions.
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            err_cnt_r <= 16'd0;
        end else if (err_clr_s) begin
            err_cnt_r <= 16'd0;
        end else if (err_evt_s && (err_cnt_r != 16'hFFFF)) begin
            err_cnt_r <= err_cnt_r + 16'd1;
        end
    end

    // FILTER and CONTROL registers.
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            filt_len_r <= FILT_W'(FILTER_RESET);
            ctrl_r     <= 2'b00;
        end else begin
            if (wr_filt_s) begin
                filt_len_r <= filt_nxt_s;
            end
            if (wr_ctrl_s && avs_ctrl_byteenable[0]) begin
                ctrl_r <= avs_ctrl_writedata[1:0];
            end
        end
    end

`ifdef QDEC_INDEX_EN
    logic        fz_s;
    logic        z_prev_r;
    logic        index_seen_r;
    logic [31:0] index_pos_r;
    logic        idx_clr_s;

    qdec_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_W(FILT_W)) u_filt_z (
        .csi_MCLK_clk   (csi_MCLK_clk),
        .rsi_MRST_reset (rsi_MRST_reset),
        .din            (enc_z),
        .filt_len       (filt_len_r),
        .dout           (fz_s)
    );

    assign idx_clr_s = avs_ctrl_write && (avs_ctrl_address == ADDR_STATUS) &&
                       avs_ctrl_byteenable[0] && avs_ctrl_writedata[STAT_INDEX_BIT];

    // Index capture: position_r here is the value before this clock's count.
    // A new index event takes priority over a same-clock clear.
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            z_prev_r     <= 1'b0;
            index_seen_r <= 1'b0;
            index_pos_r  <= 32'd0;
        end else begin
            z_prev_r <= fz_s;
            if (fz_s && !z_prev_r && ctrl_r[CTRL_EN_BIT]) begin
                index_pos_r  <= position_r;
                index_seen_r <= 1'b1;
            end else if (idx_clr_s) begin
                index_seen_r <= 1'b0;
            end
        end
    end

    assign index_seen_s = index_seen_r;
    assign index_pos_s  = index_pos_r;
`else
    assign index_seen_s = 1'b0;
    assign index_pos_s  = 32'd0;
`endif

    assign irq = index_seen_s;

    // Read multiplexer; unmapped addresses return 0.
    always_comb begin
        rd_mux_s = 32'd0;
        case (avs_ctrl_address)
            ADDR_POSITION:  rd_mux_s = position_r;
            ADDR_FILTER:    rd_mux_s = 32'(filt_len_r);
            ADDR_CONTROL:   rd_mux_s = {30'd0, ctrl_r};
            ADDR_STATUS:    rd_mux_s = {err_cnt_r, 14'd0, dir_r, index_seen_s};
            ADDR_INDEX_POS: rd_mux_s = index_pos_s;
            default:        rd_mux_s = 32'd0;
        endcase
    end

    // Registered read data, one clock after the read strobe.
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            readdata_r <= 32'd0;
        end else if (avs_ctrl_read) begin
            readdata_r <= rd_mux_s;
        end
    end

endmodule

// File: tb/tb_quadrature_decoder.sv
// -----------------------------------------------------------------------------
// tb_quadrature_decoder
// Directed self-checking bench for quadrature_decoder. Expected values are
// hand-computed; the QDEC_INDEX_EN section runs only when that macro is set.
// -----------------------------------------------------------------------------
module tb_quadrature_decoder;

    logic        clk;
    logic        rst;
    logic [2:0]  addr;
    logic        wr;
    logic        rd;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        waitreq;
    logic        enc_a;
    logic        enc_b;
`ifdef QDEC_INDEX_EN
    logic        enc_z;
`endif
    logic        dir;
    logic        irq;

    int          n_checks;
    int          n_errors;
    logic [31:0] rv;

    quadrature_decoder #(.SYNC_STAGES(2), .FILT_W(8)) dut (
        .csi_MCLK_clk         (clk),
        .rsi_MRST_reset       (rst),
        .avs_ctrl_address     (addr),
        .avs_ctrl_write       (wr),
        .avs_ctrl_read        (rd),
        .avs_ctrl_writedata   (wdata),
        .avs_ctrl_byteenable  (be),
        .avs_ctrl_readdata    (rdata),
        .avs_ctrl_waitrequest (waitreq),
        .enc_a                (enc_a),
        .enc_b                (enc_b),
`ifdef QDEC_INDEX_EN
        .enc_z                (enc_z),
`endif
        .dir                  (dir),
        .irq                  (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] b);
        @(negedge clk);
        addr = a; wdata = d; be = b; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a; rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        d = rdata;
    endtask

    // Drive a new encoder state and let it settle.
    task automatic enc_step(input logic a, input logic b);
        @(negedge clk);
        enc_a = a; enc_b = b;
        repeat (20) @(negedge clk);
    endtask

    task automatic check_reset_state(input string pfx);
        check({pfx, "_readdata"}, rdata, 32'd0);
        check({pfx, "_dir"}, {31'd0, dir}, 32'd0);
        check({pfx, "_irq"}, {31'd0, irq}, 32'd0);
        bus_read(3'd0, rv); check({pfx, "_position"}, rv, 32'd0);
        bus_read(3'd1, rv); check({pfx, "_filter"}, rv, 32'd3);
        bus_read(3'd2, rv); check({pfx, "_control"}, rv, 32'd0);
        bus_read(3'd3, rv); check({pfx, "_status"}, rv, 32'd0);
        bus_read(3'd4, rv); check({pfx, "_index_pos"}, rv, 32'd0);
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        rst = 1'b1; addr = 3'd0; wr = 1'b0; rd = 1'b0; wdata = 32'd0; be = 4'd0;
        enc_a = 1'b0; enc_b = 1'b0;
`ifdef QDEC_INDEX_EN
        enc_z = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("waitrequest", {31'd0, waitreq}, 32'd0);
        check_reset_state("rst");

        // 8 forward steps with FILTER=0
        bus_write(3'd1, 32'd0, 4'hF);
        bus_write(3'd2, 32'd1, 4'hF);
        for (int i = 0; i < 2; i++) begin
            enc_step(1'b0, 1'b1);
            enc_step(1'b1, 1'b1);
            enc_step(1'b1, 1'b0);
            enc_step(1'b0, 1'b0);
        end
        bus_read(3'd0, rv); check("fwd8_position", rv, 32'd8);
        check("fwd8_dir", {31'd0, dir}, 32'd1);

        // Reverse step from 0, then same-direction step with reverse=1
        bus_write(3'd0, 32'd0, 4'hF);
        enc_step(1'b1, 1'b0);
        bus_read(3'd0, rv); check("rev_position", rv, 32'hFFFF_FFFF);
        check("rev_dir", {31'd0, dir}, 32'd0);
        bus_write(3'd2, 32'd3, 4'hF);
        enc_step(1'b1, 1'b1);
        bus_read(3'd0, rv); check("revflag_position", rv, 32'd0);
        check("revflag_dir", {31'd0, dir}, 32'd1);
        bus_write(3'd2, 32'd1, 4'hF);

        // FILTER=3: 3-clock glitch rejected, stable edge counted
        bus_write(3'd1, 32'd3, 4'hF);
        @(negedge clk); enc_a = 1'b0;
        repeat (3) @(negedge clk);
        enc_a = 1'b1;
        repeat (20) @(negedge clk);
        bus_read(3'd0, rv); check("glitch_position", rv, 32'd0);
        bus_read(3'd3, rv); check("glitch_status", rv, 32'h0000_0002);
        enc_step(1'b1, 1'b0);
        bus_read(3'd0, rv); check("stable_position", rv, 32'd1);
        enc_step(1'b0, 1'b0);
        bus_read(3'd0, rv); check("stable2_position", rv, 32'd2);

        // Double transition 00 -> 11: error, no count, dir kept
        enc_step(1'b1, 1'b1);
        bus_read(3'd3, rv); check("err_status", rv, 32'h0001_0002);
        bus_read(3'd0, rv); check("err_position", rv, 32'd2);
        bus_write(3'd3, 32'h0000_0100, 4'h3);
        bus_read(3'd3, rv); check("errclr_status", rv, 32'h0000_0002);

        // Wrap at 0x7FFFFFFF
        bus_write(3'd0, 32'h7FFF_FFFF, 4'hF);
        enc_step(1'b1, 1'b0);
        bus_read(3'd0, rv); check("wrap_up", rv, 32'h8000_0000);
        enc_step(1'b1, 1'b1);
        bus_read(3'd0, rv); check("wrap_down", rv, 32'h7FFF_FFFF);

        // Disabled: no count, but previous state keeps tracking
        bus_write(3'd2, 32'd0, 4'hF);
        enc_step(1'b1, 1'b0);
        bus_read(3'd0, rv); check("disabled_position", rv, 32'h7FFF_FFFF);
        bus_write(3'd2, 32'd1, 4'hF);
        enc_step(1'b0, 1'b0);
        bus_read(3'd0, rv); check("reenabled_position", rv, 32'h8000_0000);

        // Byte enables, ignored writes, unmapped address
        bus_write(3'd0, 32'hFFFF_FFFF, 4'b0101);
        bus_read(3'd0, rv); check("be_position", rv, 32'h80FF_00FF);
        bus_write(3'd1, 32'h0000_0077, 4'b0000);
        bus_read(3'd1, rv); check("be0_filter", rv, 32'd3);
        bus_write(3'd5, 32'hDEAD_BEEF, 4'hF);
        bus_read(3'd5, rv); check("unmapped_read", rv, 32'd0);
        bus_read(3'd2, rv); check("control_read", rv, 32'd1);

        // POSITION write in the same clock as a count event (FILTER=0:
        // count lands on the 4th rising edge after the input change)
        bus_write(3'd1, 32'd0, 4'hF);
        @(negedge clk); enc_b = 1'b1;
        repeat (3) @(negedge clk);
        addr = 3'd0; wdata = 32'h0000_0055; be = 4'hF; wr = 1'b1;
        @(negedge clk); wr = 1'b0;
        repeat (10) @(negedge clk);
        bus_read(3'd0, rv); check("wrwins_position", rv, 32'h0000_0055);
        enc_step(1'b0, 1'b0);
        bus_read(3'd0, rv); check("after_wr_position", rv, 32'h0000_0054);

`ifdef QDEC_INDEX_EN
        // Index capture and W1C
        bus_write(3'd0, 32'd100, 4'hF);
        @(negedge clk); enc_z = 1'b1;
        repeat (20) @(negedge clk);
        enc_z = 1'b0;
        repeat (20) @(negedge clk);
        bus_read(3'd4, rv); check("index_pos", rv, 32'd100);
        check("index_irq", {31'd0, irq}, 32'd1);
        bus_write(3'd3, 32'd1, 4'h1);
        check("index_irq_clr", {31'd0, irq}, 32'd0);
`endif

        // Reset asserted mid-count
        @(negedge clk); enc_b = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        enc_b = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check_reset_state("midrst");

        // First count after release starts from 0
        bus_write(3'd2, 32'd1, 4'hF);
        enc_step(1'b0, 1'b1);
        bus_read(3'd0, rv); check("postrst_position", rv, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
